// File: rtl/wddl_dual_rail_sequencer.sv
// Drives single-ended words into a WDDL dual-rail network as alternating
// evaluation and all-zero precharge waves, and returns the sampled result with pair-integrity flags.
module wddl_dual_rail_sequencer #(
    parameter int WIDTH       = 8,
    parameter int EVAL_CYCLES = 2,
    parameter int PRE_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] wddl_t,
    output logic [WIDTH-1:0] wddl_f,
    input  logic [WIDTH-1:0] ret_t,
    input  logic [WIDTH-1:0] ret_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             pre_err
);

    localparam int MAXC = (EVAL_CYCLES > PRE_CYCLES) ? EVAL_CYCLES : PRE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_PRE  = 2'd2
    } state_t;

    // A valid WDDL pair is 01 or 10; 00 or 11 after evaluation means a broken pair.
    function automatic logic pair_fault(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
        return |(t ~^ f);
    endfunction

    function automatic logic any_rail_high(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
        return |(t | f);
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rail_t_q, rail_t_d;
    logic [WIDTH-1:0]  rail_f_q, rail_f_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic              pre_err_q, pre_err_d;

    assign in_ready  = (state_q == ST_IDLE) && !out_valid_q;
    assign wddl_t    = rail_t_q;
    assign wddl_f    = rail_f_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign pre_err   = pre_err_q;

    // Next-state, rail and result computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rail_t_d    = {WIDTH{1'b0}};
        rail_f_d    = {WIDTH{1'b0}};
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        pre_err_d   = pre_err_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d  = ST_EVAL;
                    cnt_d    = CW'(EVAL_CYCLES - 1);
                    rail_t_d = in_data;
                    rail_f_d = ~in_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (cnt_q == {CW{1'b0}}) begin
                    out_data_d  = ret_t;
                    out_err_d   = pair_fault(ret_t, ret_f);
                    out_valid_d = 1'b1;
                    cnt_d       = CW'(PRE_CYCLES - 1);
                    state_d     = ST_PRE;
                end else begin
                    cnt_d    = cnt_q - CW'(1);
                    rail_t_d = rail_t_q;
                    rail_f_d = rail_f_q;
                end
            end
            ST_PRE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    if (any_rail_high(ret_t, ret_f)) begin
                        pre_err_d = 1'b1;
                    end else begin
                        pre_err_d = pre_err_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            rail_t_q    <= {WIDTH{1'b0}};
            rail_f_q    <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_err_q   <= 1'b0;
            pre_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rail_t_q    <= rail_t_d;
            rail_f_q    <= rail_f_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            pre_err_q   <= pre_err_d;
        end
    end

endmodule

// File: tb/tb_wddl_dual_rail_sequencer.sv
// Directed bench for wddl_dual_rail_sequencer: default instance plus an EVAL=1/PRE=3 instance,
// each closed through an identity network with injectable rail faults.
module tb_wddl_dual_rail_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_err, pre_err;
    logic [7:0] in_data, wddl_t, wddl_f, ret_t, ret_f, out_data;
    logic [7:0] inj_t, inj_f;

    logic       p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_out_err, p_pre_err;
    logic [7:0] p_in_data, p_wddl_t, p_wddl_f, p_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign ret_t = wddl_t | inj_t;
    assign ret_f = wddl_f | inj_f;

    wddl_dual_rail_sequencer u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wddl_t(wddl_t), .wddl_f(wddl_f), .ret_t(ret_t), .ret_f(ret_f),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .pre_err(pre_err)
    );

    wddl_dual_rail_sequencer #(.WIDTH(8), .EVAL_CYCLES(1), .PRE_CYCLES(3)) u_dut_p (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .wddl_t(p_wddl_t), .wddl_f(p_wddl_f), .ret_t(p_wddl_t), .ret_f(p_wddl_f),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .out_err(p_out_err), .pre_err(p_pre_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset_state();
        rst = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (wddl_t !== 8'h00 || wddl_f !== 8'h00) begin n_bad++; $display("FAIL rst_rails: got %h/%h want 00/00", wddl_t, wddl_f); end
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out: got v%b d%h e%b want v0 d00 e0", out_valid, out_data, out_err); end
        n_cmp++; if (pre_err !== 1'b0 || p_pre_err !== 1'b0) begin n_bad++; $display("FAIL rst_pre_err: got %b/%b want 0/0", pre_err, p_pre_err); end
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_eval();
        tick();
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wddl_t !== 8'hA5 || wddl_f !== 8'h5A) begin n_bad++; $display("FAIL rme_eval_rails: got %h/%h want a5/5a", wddl_t, wddl_f); end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (wddl_t !== 8'h00 || wddl_f !== 8'h00) begin n_bad++; $display("FAIL rme_rails: got %h/%h want 00/00", wddl_t, wddl_f); end
        n_cmp++; if (out_valid !== 1'b0 || pre_err !== 1'b0) begin n_bad++; $display("FAIL rme_flags: got v%b p%b want v0 p0", out_valid, pre_err); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rme_in_ready: got %b want 1", in_ready); end
        tick(); tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rme_discard: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_single_word();
        tick();
        out_ready = 1'b1; in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wddl_t !== 8'h3C || wddl_f !== 8'hC3) begin n_bad++; $display("FAIL single_n1: got %h/%h want 3c/c3", wddl_t, wddl_f); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL single_busy: got in_ready %b want 0", in_ready); end
        tick();
        n_cmp++; if (wddl_t !== 8'h3C || wddl_f !== 8'hC3 || out_valid !== 1'b0) begin n_bad++; $display("FAIL single_n2: got %h/%h v%b want 3c/c3 v0", wddl_t, wddl_f, out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_err !== 1'b0) begin n_bad++; $display("FAIL single_result: got v%b d%h e%b want v1 d3c e0", out_valid, out_data, out_err); end
        n_cmp++; if (wddl_t !== 8'h00 || wddl_f !== 8'h00 || in_ready !== 1'b0) begin n_bad++; $display("FAIL single_pre: got %h/%h r%b want 00/00 r0", wddl_t, wddl_f, in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || pre_err !== 1'b0) begin n_bad++; $display("FAIL single_idle: got r%b v%b p%b want r1 v0 p0", in_ready, out_valid, pre_err); end
    endtask

    task automatic test_stream();
        logic [7:0] words [3];
        int         acc [3];
        int         k, last, d;
        bit         pend;
        logic [7:0] lw, et, ef;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h5A;
        acc[0] = -1; acc[1] = -1; acc[2] = -1;
        k = 0; last = -100; pend = 1'b0; lw = 8'h00;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (pend) begin
                pend = 1'b0;
                if (k < 3) in_data = words[k];
                else in_valid = 1'b0;
            end
            if (c == 0) begin in_valid = 1'b1; in_data = words[0]; end
            d  = c - last;
            et = (d == 1 || d == 2) ? lw : 8'h00;
            ef = (d == 1 || d == 2) ? ~lw : 8'h00;
            n_cmp++; if (wddl_t !== et || wddl_f !== ef) begin n_bad++; $display("FAIL stream_rails c%0d: got %h/%h want %h/%h", c, wddl_t, wddl_f, et, ef); end
            n_cmp++; if (out_valid !== (d == 3)) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, (d == 3)); end
            if (d == 3) begin
                n_cmp++; if (out_data !== lw || out_err !== 1'b0) begin n_bad++; $display("FAIL stream_data c%0d: got %h e%b want %h e0", c, out_data, out_err, lw); end
            end
            if (in_valid && in_ready) begin
                if (k < 3) acc[k] = c;
                last = c; lw = in_data; k++; pend = 1'b1;
            end
        end
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL stream_count: got %0d want 3", k); end
        n_cmp++; if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin n_bad++; $display("FAIL stream_rate: got %0d,%0d,%0d want 0,4,8", acc[0], acc[1], acc[2]); end
    endtask

    task automatic test_backpressure();
        tick();
        in_data = 8'h96; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_data = 8'h69;
        tick();
        for (int c = 3; c < 13; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h96 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold c%0d: got v%b d%h r%b want v1 d96 r0", c, out_valid, out_data, in_ready); end
        end
        tick();
        out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_release: got v%b r%b want v1 r0", out_valid, in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_free: got v%b r%b want v0 r1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wddl_t !== 8'h69 || wddl_f !== 8'h96) begin n_bad++; $display("FAIL bp_next_rails: got %h/%h want 69/96", wddl_t, wddl_f); end
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h69) begin n_bad++; $display("FAIL bp_next_result: got v%b d%h want v1 d69", out_valid, out_data); end
        tick();
    endtask

    task automatic test_pair_fault();
        tick();
        out_ready = 1'b1; in_data = 8'h40; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; inj_t = 8'h08; inj_f = 8'h08;
        tick();
        tick();
        inj_t = 8'h00; inj_f = 8'h00;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h48 || out_err !== 1'b1) begin n_bad++; $display("FAIL pair_err: got v%b d%h e%b want v1 d48 e1", out_valid, out_data, out_err); end
        tick();
        n_cmp++; if (pre_err !== 1'b0) begin n_bad++; $display("FAIL pair_no_pre_err: got %b want 0", pre_err); end
        // Precharge fault: a true rail still high when the precharge wave ends.
        in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        inj_t = 8'h01;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_err !== 1'b0) begin n_bad++; $display("FAIL pre_word: got v%b d%h e%b want v1 d11 e0", out_valid, out_data, out_err); end
        tick();
        inj_t = 8'h00;
        n_cmp++; if (pre_err !== 1'b1) begin n_bad++; $display("FAIL pre_err_set: got %b want 1", pre_err); end
        in_data = 8'h22; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (out_data !== 8'h22 || out_err !== 1'b0 || pre_err !== 1'b1) begin n_bad++; $display("FAIL pre_err_sticky: got d%h e%b p%b want d22 e0 p1", out_data, out_err, pre_err); end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (pre_err !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL pre_err_clear: got p%b v%b want p0 v0", pre_err, out_valid); end
    endtask

    task automatic test_params();
        tick();
        p_out_ready = 1'b1; p_in_data = 8'hC5; p_in_valid = 1'b1;
        n_cmp++; if (p_in_ready !== 1'b1) begin n_bad++; $display("FAIL par_ready0: got %b want 1", p_in_ready); end
        tick();
        p_in_data = 8'h3B;
        n_cmp++; if (p_wddl_t !== 8'hC5 || p_wddl_f !== 8'h3A) begin n_bad++; $display("FAIL par_eval: got %h/%h want c5/3a", p_wddl_t, p_wddl_f); end
        tick();
        n_cmp++; if (p_wddl_t !== 8'h00 || p_wddl_f !== 8'h00 || p_out_valid !== 1'b1 || p_out_data !== 8'hC5) begin n_bad++; $display("FAIL par_result: got %h/%h v%b d%h want 00/00 v1 dc5", p_wddl_t, p_wddl_f, p_out_valid, p_out_data); end
        for (int c = 3; c < 5; c++) begin
            tick();
            n_cmp++; if (p_wddl_t !== 8'h00 || p_wddl_f !== 8'h00 || p_in_ready !== 1'b0) begin n_bad++; $display("FAIL par_pre c%0d: got %h/%h r%b want 00/00 r0", c, p_wddl_t, p_wddl_f, p_in_ready); end
        end
        tick();
        n_cmp++; if (p_in_ready !== 1'b1) begin n_bad++; $display("FAIL par_rate: got in_ready %b want 1", p_in_ready); end
        tick();
        p_in_valid = 1'b0;
        n_cmp++; if (p_wddl_t !== 8'h3B || p_wddl_f !== 8'hC4) begin n_bad++; $display("FAIL par_second: got %h/%h want 3b/c4", p_wddl_t, p_wddl_f); end
        tick();
        n_cmp++; if (p_out_data !== 8'h3B || p_out_err !== 1'b0 || p_pre_err !== 1'b0) begin n_bad++; $display("FAIL par_second_result: got d%h e%b p%b want d3b e0 p0", p_out_data, p_out_err, p_pre_err); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        inj_t = 8'h00; inj_f = 8'h00;
        p_in_valid = 1'b0; p_in_data = 8'h00; p_out_ready = 1'b0;
        test_reset_state();
        test_reset_mid_eval();
        test_single_word();
        test_stream();
        test_backpressure();
        test_pair_fault();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
